// File: rtl/ofs_fim_pcie_ss_tx_dense_buf.sv
// Store-and-forward TX beat buffer: a packet is released only once fully resident so the
// downstream merge sees it without bubbles; a packet larger than the buffer falls back to cut-through.
module ofs_fim_pcie_ss_tx_dense_buf #(
  parameter int TDATA_WIDTH = 512,
  parameter int TUSER_WIDTH = 20,
  parameter int NUM_OF_SEG  = 2,
  parameter int DEPTH       = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_tvalid,
  output logic                         in_tready,
  input  logic [TDATA_WIDTH-1:0]       in_tdata,
  input  logic [TDATA_WIDTH/8-1:0]     in_tkeep,
  input  logic                         in_tlast,
  input  logic [TUSER_WIDTH-1:0]       in_tuser_vendor,
  output logic                         out_tvalid,
  input  logic                         out_tready,
  output logic [TDATA_WIDTH-1:0]       out_tdata,
  output logic [TDATA_WIDTH/8-1:0]     out_tkeep,
  output logic                         out_tlast,
  output logic [TUSER_WIDTH-1:0]       out_tuser_vendor,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level,
  output logic [$clog2(DEPTH+1)-1:0]   pkt_count,
  output logic                         err_oversize
);

  // Width of ofs_fim_pcie_ss_shims_pkg::t_tuser_seg.
  localparam int SEG_W  = 10;
  localparam int KEEP_W = TDATA_WIDTH / 8;
  localparam int BEAT_W = TDATA_WIDTH + KEEP_W + 1 + TUSER_WIDTH;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "DEPTH must be a power of 2 and at least 4");
  end
  if (TUSER_WIDTH != NUM_OF_SEG * SEG_W) begin : g_bad_tuser
    $fatal(1, "TUSER_WIDTH must equal NUM_OF_SEG * $bits(t_tuser_seg)");
  end

  typedef enum logic {ST_STORE, ST_CUT} state_t;

  logic [BEAT_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_last_vec;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_ram_cnt;
  logic [CNT_W-1:0]  r_rdy_pkts;
  logic [CNT_W-1:0]  r_fill;
  logic [CNT_W-1:0]  r_pkts;
  logic              r_rd_valid;
  logic [BEAT_W-1:0] r_rd_data;
  logic [BEAT_W-1:0] r_sk_data [2];
  logic              r_sk_wr;
  logic              r_sk_rd;
  logic [1:0]        r_sk_cnt;
  state_t            r_state;
  logic              r_cut_last_rd;
  logic              r_err;

  logic              w_push;
  logic              w_pop;
  logic              w_rd;
  logic              w_rd_last;
  logic              w_room;
  logic              w_can_rd;
  logic [2:0]        w_sk_load;
  logic [BEAT_W-1:0] w_in_beat;

  assign in_tready    = !rst && (r_fill < CNT_W'(DEPTH));
  assign w_push       = in_tvalid && in_tready;
  assign out_tvalid   = (r_sk_cnt != 2'd0);
  assign w_pop        = out_tvalid && out_tready;
  assign w_in_beat    = {in_tdata, in_tkeep, in_tlast, in_tuser_vendor};
  assign {out_tdata, out_tkeep, out_tlast, out_tuser_vendor} = r_sk_data[r_sk_rd];
  assign fill_level   = r_fill;
  assign pkt_count    = r_pkts;
  assign err_oversize = r_err;

  // A read issued now lands in the skid next cycle, so count the in-flight beat as occupied.
  assign w_sk_load = {1'b0, r_sk_cnt} + {2'b00, r_rd_valid};
  assign w_room    = w_pop ? (w_sk_load < 3'd3) : (w_sk_load < 3'd2);
  assign w_rd_last = r_last_vec[r_rd_ptr];

  // r_rdy_pkts counts complete packets whose tlast is still unread, so the head unread beat
  // belongs to a complete packet whenever it is non-zero.
  assign w_can_rd = (r_state == ST_STORE) ? (r_rdy_pkts != '0)
                                          : ((r_ram_cnt != '0) && !r_cut_last_rd);
  assign w_rd     = w_room && w_can_rd;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in_beat;
    end
    if (w_rd) begin
      r_rd_data <= r_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_last_vec[r_wr_ptr] <= in_tlast;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_ram_cnt  <= '0;
      r_rdy_pkts <= '0;
      r_fill     <= '0;
      r_pkts     <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_rd_valid <= w_rd;
      r_ram_cnt  <= r_ram_cnt + CNT_W'(w_push) - CNT_W'(w_rd);
      r_rdy_pkts <= r_rdy_pkts + CNT_W'(w_push && in_tlast) - CNT_W'(w_rd && w_rd_last);
      r_fill     <= r_fill + CNT_W'(w_push) - CNT_W'(w_pop);
      r_pkts     <= r_pkts + CNT_W'(w_push && in_tlast) - CNT_W'(w_pop && out_tlast);
    end
  end

  always_ff @(posedge clk) begin
    if (r_rd_valid) begin
      r_sk_data[r_sk_wr] <= r_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sk_wr  <= 1'b0;
      r_sk_rd  <= 1'b0;
      r_sk_cnt <= 2'd0;
    end else begin
      if (r_rd_valid) begin
        r_sk_wr <= ~r_sk_wr;
      end
      if (w_pop) begin
        r_sk_rd <= ~r_sk_rd;
      end
      r_sk_cnt <= r_sk_cnt + {1'b0, r_rd_valid} - {1'b0, w_pop};
    end
  end

  // In CUT mode reading stops after the oversized packet's tlast so the following
  // packet is again gated as a whole once STORE resumes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_STORE;
      r_err         <= 1'b0;
      r_cut_last_rd <= 1'b0;
    end else begin
      case (r_state)
        ST_STORE: begin
          if ((r_fill == CNT_W'(DEPTH)) && (r_pkts == '0)) begin
            r_state <= ST_CUT;
            r_err   <= 1'b1;
          end
        end
        ST_CUT: begin
          if (w_rd && w_rd_last) begin
            r_cut_last_rd <= 1'b1;
          end
          if (w_pop && out_tlast) begin
            r_state       <= ST_STORE;
            r_cut_last_rd <= 1'b0;
          end
        end
        default: r_state <= ST_STORE;
      endcase
    end
  end

endmodule

// File: tb/tb_ofs_fim_pcie_ss_tx_dense_buf.sv
// Directed bench for the dense TX buffer: cycle table for the store gate, plus
// sequences for streaming, full, oversize, simultaneous update and mid-packet reset.
module tb_ofs_fim_pcie_ss_tx_dense_buf;

  localparam int TDW   = 512;
  localparam int KW    = TDW / 8;
  localparam int TUW   = 20;
  localparam int DEPTH = 64;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [TDW-1:0] d;
    logic [KW-1:0]  k;
    logic           l;
    logic [TUW-1:0] u;
  } beat_t;

  typedef struct {
    bit vin;
    int id;
    bit lin;
    bit exp_ov;
    int exp_id;
    int exp_fill;
    int exp_pkt;
  } row_t;

  logic           clk;
  logic           rst;
  logic           in_tvalid;
  logic           in_tready;
  logic [TDW-1:0] in_tdata;
  logic [KW-1:0]  in_tkeep;
  logic           in_tlast;
  logic [TUW-1:0] in_tuser_vendor;
  logic           out_tvalid;
  logic           out_tready;
  logic [TDW-1:0] out_tdata;
  logic [KW-1:0]  out_tkeep;
  logic           out_tlast;
  logic [TUW-1:0] out_tuser_vendor;
  logic [CW-1:0]  fill_level;
  logic [CW-1:0]  pkt_count;
  logic           err_oversize;

  logic rdy_mode;
  logic rdy_val;
  logic rnd_bit;

  int    checks;
  int    errors;
  int    pops;
  int    bubbles;
  bit    in_pkt;
  beat_t exp_q[$];

  assign out_tready = rdy_mode ? rnd_bit : rdy_val;

  ofs_fim_pcie_ss_tx_dense_buf #(
    .TDATA_WIDTH(TDW),
    .TUSER_WIDTH(TUW),
    .NUM_OF_SEG (2),
    .DEPTH      (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_tvalid       (in_tvalid),
    .in_tready       (in_tready),
    .in_tdata        (in_tdata),
    .in_tkeep        (in_tkeep),
    .in_tlast        (in_tlast),
    .in_tuser_vendor (in_tuser_vendor),
    .out_tvalid      (out_tvalid),
    .out_tready      (out_tready),
    .out_tdata       (out_tdata),
    .out_tkeep       (out_tkeep),
    .out_tlast       (out_tlast),
    .out_tuser_vendor(out_tuser_vendor),
    .fill_level      (fill_level),
    .pkt_count       (pkt_count),
    .err_oversize    (err_oversize)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #1;
    rnd_bit = 1'($urandom_range(1, 0));
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic beat_t mk(input int id, input bit last);
    beat_t b;
    for (int w = 0; w < TDW / 32; w++) begin
      b.d[32*w +: 32] = {id[15:0], 16'(w)} ^ 32'h3C5A_0000;
    end
    b.k = ~{8{id[7:0]}};
    b.l = last;
    b.u = 20'(id * 7 + 3);
    return b;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic check_beat(input string name, input beat_t act, input beat_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got last=%0b user=%0h d0=%0h want last=%0b user=%0h d0=%0h at %0t",
               name, act.l, act.u, act.d[31:0], exp.l, exp.u, exp.d[31:0], $time);
    end else begin
      $display("ok   %s user=%0h last=%0b", name, act.u, act.l);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s bound expired at %0t", name, $time);
  endtask

  // Scoreboard: accepted input beats are queued and every popped beat must match the head.
  task automatic mon();
    beat_t act;
    beat_t exp;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        in_pkt = 1'b0;
      end else begin
        if (out_tvalid && out_tready) begin
          act = {out_tdata, out_tkeep, out_tlast, out_tuser_vendor};
          pops++;
          if (exp_q.size() == 0) begin
            fail_now("pop_with_empty_model");
          end else begin
            exp = exp_q.pop_front();
            check_beat("pop_beat", act, exp);
          end
          in_pkt = !out_tlast;
        end else if (in_pkt && out_tready && !out_tvalid) begin
          bubbles++;
        end
        if (in_tvalid && in_tready) begin
          exp_q.push_back({in_tdata, in_tkeep, in_tlast, in_tuser_vendor});
        end
      end
    end
  endtask

  task automatic drive_beat(input int id, input bit last);
    beat_t b;
    b = mk(id, last);
    in_tvalid       = 1'b1;
    in_tdata        = b.d;
    in_tkeep        = b.k;
    in_tlast        = b.l;
    in_tuser_vendor = b.u;
  endtask

  task automatic send_beat(input int id, input bit last);
    bit acc;
    int guard;
    drive_beat(id, last);
    acc   = 1'b0;
    guard = 0;
    while (!acc) begin
      @(negedge clk);
      acc = in_tready;
      @(posedge clk);
      #1;
      guard++;
      if (!acc && guard > 2000) begin
        fail_now("send_beat");
        acc = 1'b1;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int guard;
    guard = 0;
    while ((fill_level != '0 || out_tvalid) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) fail_now(name);
    check({name, "_fill"}, 64'(fill_level), 64'd0);
    check({name, "_model_empty"}, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    row_t tbl[16];
    int   sizes[10];
    int   next_id;
    int   pops0;
    int   vcnt;
    beat_t exp_b;

    tbl[0]  = '{1, 1, 0, 0, 0, 1, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 1, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 1, 0};
    tbl[3]  = '{1, 2, 0, 0, 0, 2, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 2, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 2, 0};
    tbl[6]  = '{1, 3, 0, 0, 0, 3, 0};
    tbl[7]  = '{0, 0, 0, 0, 0, 3, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 3, 0};
    tbl[9]  = '{1, 4, 1, 0, 0, 4, 1};
    tbl[10] = '{0, 0, 0, 0, 0, 4, 1};
    tbl[11] = '{0, 0, 0, 1, 1, 4, 1};
    tbl[12] = '{0, 0, 0, 1, 2, 3, 1};
    tbl[13] = '{0, 0, 0, 1, 3, 2, 1};
    tbl[14] = '{0, 0, 0, 1, 4, 1, 1};
    tbl[15] = '{0, 0, 0, 0, 0, 0, 0};
    sizes   = '{3, 1, 8, 2, 5, 7, 4, 6, 1, 8};
    next_id = 100;

    checks = 0; errors = 0; pops = 0; bubbles = 0; in_pkt = 1'b0;
    rst = 1'b1; rdy_mode = 1'b0; rdy_val = 1'b0; rnd_bit = 1'b0;
    in_tvalid = 1'b0; in_tdata = '0; in_tkeep = '0; in_tlast = 1'b0; in_tuser_vendor = '0;
    fork
      mon();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_tready_low", 64'(in_tready), 64'd0);
    check("rst_out_tvalid", 64'(out_tvalid), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_fill", 64'(fill_level), 64'd0);
    check("rst_pkt", 64'(pkt_count), 64'd0);
    check("rst_err", 64'(err_oversize), 64'd0);
    check("rst_in_tready_high", 64'(in_tready), 64'd1);

    // Store gate, one table row per clock
    rdy_val = 1'b1;
    foreach (tbl[i]) begin
      if (tbl[i].vin) drive_beat(tbl[i].id, tbl[i].lin);
      else in_tvalid = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("sg%0d_valid", i), 64'(out_tvalid), 64'(tbl[i].exp_ov));
      check($sformatf("sg%0d_fill", i), 64'(fill_level), 64'(tbl[i].exp_fill));
      check($sformatf("sg%0d_pkt", i), 64'(pkt_count), 64'(tbl[i].exp_pkt));
      if (tbl[i].exp_ov) begin
        exp_b = mk(tbl[i].exp_id, tbl[i].exp_id == 4);
        check_beat($sformatf("sg%0d_beat", i), {out_tdata, out_tkeep, out_tlast, out_tuser_vendor}, exp_b);
      end
    end
    in_tvalid = 1'b0;

    // Back-to-back packets with random ready
    bubbles = 0;
    pops0 = pops;
    rdy_mode = 1'b1;
    foreach (sizes[p]) begin
      for (int b = 0; b < sizes[p]; b++) begin
        send_beat(next_id, b == sizes[p] - 1);
        next_id++;
      end
    end
    in_tvalid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rdy_mode = 1'b0;
    rdy_val  = 1'b1;
    wait_drain("b2b_drain");
    check("b2b_pops", 64'(pops - pops0), 64'd45);
    check("b2b_bubbles", 64'(bubbles), 64'd0);
    check("b2b_err", 64'(err_oversize), 64'd0);

    // Full buffer with output stalled
    rdy_val = 1'b0;
    for (int b = 0; b < 64; b++) begin
      send_beat(next_id, (b % 4) == 3);
      next_id++;
    end
    drive_beat(next_id, 1'b0);
    #1;
    check("full_in_tready", 64'(in_tready), 64'd0);
    check("full_fill", 64'(fill_level), 64'd64);
    check("full_pkt", 64'(pkt_count), 64'd16);
    repeat (3) @(posedge clk);
    #1;
    check("full_hold_fill", 64'(fill_level), 64'd64);
    check("full_err", 64'(err_oversize), 64'd0);
    in_tvalid = 1'b0;
    rdy_val   = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (out_tvalid) vcnt++;
      @(posedge clk);
    end
    #1;
    check("full_drain_valid_cycles", 64'(vcnt), 64'd64);
    check("full_drain_fill", 64'(fill_level), 64'd0);
    check("full_drain_out_tvalid", 64'(out_tvalid), 64'd0);

    // Oversize packet falls back to cut-through
    pops0 = pops;
    fork
      begin
        for (int b = 0; b < 70; b++) send_beat(next_id + b, b == 69);
        in_tvalid = 1'b0;
      end
      begin
        int g;
        g = 0;
        do begin
          @(negedge clk);
          g++;
        end while (fill_level != CW'(DEPTH) && g < 500);
        check("ovf_fill_reached", 64'(fill_level), 64'd64);
        check("ovf_err_before", 64'(err_oversize), 64'd0);
        @(negedge clk);
        check("ovf_err_rise", 64'(err_oversize), 64'd1);
        g = 0;
        while (!out_tvalid && g < 10) begin
          @(negedge clk);
          g++;
        end
        check("ovf_cut_out_tvalid", 64'(out_tvalid), 64'd1);
        check("ovf_cut_pkt", 64'(pkt_count), 64'd0);
      end
    join
    next_id += 70;
    wait_drain("ovf_drain");
    check("ovf_pops", 64'(pops - pops0), 64'd70);
    check("ovf_err_sticky", 64'(err_oversize), 64'd1);
    send_beat(next_id, 1'b0);
    send_beat(next_id + 1, 1'b0);
    in_tvalid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("ovf_store_gate_valid", 64'(out_tvalid), 64'd0);
    check("ovf_store_gate_fill", 64'(fill_level), 64'd2);
    send_beat(next_id + 2, 1'b1);
    in_tvalid = 1'b0;
    next_id += 3;
    wait_drain("ovf_post_drain");
    check("ovf_err_still", 64'(err_oversize), 64'd1);

    // Simultaneous tlast push and tlast pop
    rdy_val = 1'b0;
    send_beat(next_id, 1'b1);
    in_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("sim_pre_valid", 64'(out_tvalid), 64'd1);
    check("sim_pre_fill", 64'(fill_level), 64'd1);
    check("sim_pre_pkt", 64'(pkt_count), 64'd1);
    drive_beat(next_id + 1, 1'b1);
    rdy_val = 1'b1;
    @(posedge clk);
    #1;
    in_tvalid = 1'b0;
    rdy_val   = 1'b0;
    check("sim_fill", 64'(fill_level), 64'd1);
    check("sim_pkt", 64'(pkt_count), 64'd1);
    next_id += 2;
    rdy_val = 1'b1;
    wait_drain("sim_drain");

    // Reset in the middle of a packet
    for (int b = 0; b < 3; b++) send_beat(next_id + b, 1'b0);
    in_tvalid = 1'b0;
    next_id += 3;
    @(posedge clk);
    #1;
    check("mrst_pre_fill", 64'(fill_level), 64'd3);
    check("mrst_pre_valid", 64'(out_tvalid), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_in_tready", 64'(in_tready), 64'd0);
    check("mrst_out_tvalid", 64'(out_tvalid), 64'd0);
    rst = 1'b0;
    #1;
    check("mrst_fill", 64'(fill_level), 64'd0);
    check("mrst_pkt", 64'(pkt_count), 64'd0);
    check("mrst_err_cleared", 64'(err_oversize), 64'd0);
    pops0 = pops;
    send_beat(next_id, 1'b0);
    send_beat(next_id + 1, 1'b1);
    in_tvalid = 1'b0;
    wait_drain("mrst_drain");
    check("mrst_pops", 64'(pops - pops0), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ofs_fim_pcie_ss_tx_dense_buf.md
Name: ofs_fim_pcie_ss_tx_dense_buf

Overview:
- Store-and-forward packet buffer on the host-channel TX stream.
- Sits directly upstream of the TX/TXREQ merge stage.
- Holds TLP beats until the whole packet is resident, then emits it with no idle cycles between beats. This delivers the dense-packet guarantee the merge's segment scheduler depends on.
- tuser_vendor is carried opaquely, NUM_OF_SEG t_tuser_seg fields per beat.

Parameters:
- TDATA_WIDTH, 512: tdata width.
- TUSER_WIDTH, 20: tuser_vendor width; must equal NUM_OF_SEG * $bits(ofs_fim_pcie_ss_shims_pkg::t_tuser_seg).
- NUM_OF_SEG, 2: segments per beat; used only for the width check.
- DEPTH, 64: buffer depth in beats; power of 2, at least 4.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_tvalid  in  1  input beat valid.
- in_tready  out  1  buffer can accept a beat.
- in_tdata  in  TDATA_WIDTH  input data.
- in_tkeep  in  TDATA_WIDTH/8  input byte enables.
- in_tlast  in  1  last beat of packet.
- in_tuser_vendor  in  TUSER_WIDTH  segment sideband.
- out_tvalid  out  1  output beat valid.
- out_tready  in  1  downstream (merge) ready.
- out_tdata / out_tkeep / out_tlast / out_tuser_vendor  out  same widths as inputs  output beat.
- fill_level  out  $clog2(DEPTH+1)  beats resident.
- pkt_count  out  $clog2(DEPTH+1)  complete packets resident.
- err_oversize  out  1  sticky flag: a packet exceeded DEPTH beats.

Behaviour:
- Clock, reset and handshake:
  - One clock. Reset is synchronous and active-high. All state updates on posedge clk.
  - Push = in_tvalid && in_tready. Pop = out_tvalid && out_tready.
  - in_tready = !rst && (fill_level < DEPTH), combinational.
  - Push into a full buffer is impossible, because in_tready is low.
- Reset (rst high at an edge):
  - fill_level, pkt_count, read and write pointers cleared; err_oversize = 0; state = STORE.
  - out_tvalid = 0 in the cycle after reset and for as long as rst is held.
  - Reset mid-packet discards all buffered beats, including partial packets. No output beat is emitted for them.
- Counters:
  - fill_level += push − pop.
  - pkt_count += (push && in_tlast) − (pop && out_tlast).
  - Simultaneous increment and decrement leaves a counter unchanged.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Storage and output path:
  - Beat storage is a DEPTH-entry RAM with a registered read.
  - A 2-entry output skid register keeps out_* stable while out_tvalid && !out_tready (AXI-S rules: no drop, no change, no valid retraction).
- State machine:
  - STORE: a beat is released only when the head packet is complete (pkt_count > 0; packets are in order, so the head is complete). Every packet is presented on consecutive cycles whenever out_tready is high.
  - STORE -> CUT when fill_level == DEPTH and pkt_count == 0, i.e. one packet fills the buffer. On that transition err_oversize is set and stays set until rst.
  - CUT: beats are released whenever the buffer is non-empty. Bubbles are permitted only in this mode.
  - CUT -> STORE on the pop of a beat with out_tlast = 1.
- Latency: the tlast beat pushed at edge N gives the head beat of that packet on out_tvalid at edge N+2, when the buffer was previously empty.
- Throughput: sustained 1 beat/cycle in and out simultaneously.
- Data integrity: tdata, tkeep, tlast and tuser_vendor are passed bit-exact, in order. There is no reordering or merging.
- Elaboration checks (simulation $fatal):
  - DEPTH is a power of 2 and at least 4.
  - TUSER_WIDTH equals NUM_OF_SEG * $bits(t_tuser_seg).

Test Plan:
- Store gate: 4-beat packet pushed one beat every 3 cycles, out_tready = 1 -> out_tvalid stays 0 until 2 cycles after the tlast push, then 4 consecutive valid beats with tdata matching. pkt_count goes 0 -> 1 -> 0.
- Back-to-back: 10 packets of 1–8 beats pushed continuously with random out_tready -> output stream identical. No bubble inside any packet whenever out_tready = 1. Final fill_level = 0, err_oversize = 0.
- Full: out_tready = 0, push 16 packets of 4 beats (64 beats) -> in_tready low after beat 64, fill_level = 64, pkt_count = 16. Raising out_tready drains all 64 beats in 64 cycles.
- Oversize: single 70-beat packet with out_tready = 1 -> at fill_level = 64 err_oversize rises and stays 1, output starts and CUT mode is entered. All 70 beats are delivered in order; STORE is re-entered after the tlast pop.
- Simultaneous: buffer holds 1 complete packet; push a tlast beat in the same cycle the head tlast pops -> pkt_count unchanged at 1, fill_level unchanged.
- Reset mid-packet: 3 beats of an unterminated packet buffered, assert rst for 1 cycle -> fill_level = 0, pkt_count = 0, out_tvalid = 0. A following 2-beat packet is output alone and correctly.
